// File: rtl/cla_seq_mac_ctrl.sv
// Sequencing controller around one shared WIDTH-bit carry-lookahead adder:
// single-pass add (A+B+Cin) or shift-and-add unsigned multiply, one iteration per clock.
module cla_seq_mac_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] R
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   h;
  logic [CW-1:0]    cnt;
  logic             opr;
  logic             cr;

  // adder datapath
  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic             acin;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             gacc;
  logic             pchain;

  always_comb begin
    ax   = opr ? m : WIDTH'(h);
    ay   = opr ? q : (q[0] ? m : '0);
    acin = opr ? cr : 1'b0;
  end

  assign g = ax & ay;
  assign p = ax ^ ay;

  // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, every
  // carry formed directly from the generate/propagate terms rather than rippled.
  always_comb begin
    c      = '0;
    gacc   = 1'b0;
    pchain = 1'b1;
    c[0]   = acin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gacc   = 1'b0;
      pchain = 1'b1;
      for (int unsigned k = 0; k <= i; k++) begin
        gacc   = gacc | (pchain & g[i-k]);
        pchain = pchain & p[i-k];
      end
      c[i+1] = gacc | (pchain & acin);
    end
  end

  assign s    = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= '0;
      m     <= '0;
      q     <= '0;
      h     <= '0;
      cnt   <= '0;
      opr   <= 1'b0;
      cr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= A;
            q     <= B;
            opr   <= op;
            cr    <= Cin;
            h     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (opr) begin
            R     <= {{(WIDTH-1){1'b0}}, cout, s};
            done  <= 1'b1;
            state <= DONE;
          end else begin
            h   <= {1'b0, cout, s[WIDTH-1:1]};
            q   <= {s[0], q[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              // R taken from the just-shifted {H,Q} pair, i.e. the next-state values
              R     <= {cout, s, q[WIDTH-1:1]};
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_mac_ctrl.sv
// Self-checking bench for cla_seq_mac_ctrl (WIDTH=4): directed table, corner sequences,
// exhaustive and randomized operations against an arithmetic reference model.
module tb_cla_seq_mac_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [2*W-1:0] r;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [7:0]   exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  cla_seq_mac_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .busy (busy),
    .done (done),
    .R    (r)
  );

  function automatic logic [7:0] ref_r(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    int unsigned res;
    if (o) res = int'(x) + int'(y) + int'(ci);
    else   res = int'(x) * int'(y);
    return 8'(res);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one op from IDLE, optionally scramble inputs mid-run, then check
  // result, done latency (edges after acceptance), busy, and one-cycle done pulse.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic [7:0] exp, input bit scramble, input string name);
    int lat;
    bit busy_ok;
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); op = 1'($urandom); cin = 1'($urandom);
    end
    busy_ok = 1'b1;
    lat = 0;
    do begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 64);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_lat"}, 32'(lat), o ? 32'd1 : 32'(W));
    chk({name, "_r"}, 32'(r), 32'(exp));
    chk({name, "_busy"}, 32'(busy_ok & busy), 32'd1);
    @(posedge clk); #1;
    chk({name, "_after"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc, ndone, last, run, maxrun;
    bit seen;
    logic [W-1:0] x, y;
    logic o, ci;

    tbl[0] = '{1'b0, 4'd13, 4'd11, 1'b0, 8'h8F};
    tbl[1] = '{1'b0, 4'd15, 4'd15, 1'b0, 8'hE1};
    tbl[2] = '{1'b0, 4'd0,  4'd9,  1'b0, 8'h00};
    tbl[3] = '{1'b1, 4'd9,  4'd8,  1'b0, 8'h11};
    tbl[4] = '{1'b1, 4'd15, 4'd15, 1'b1, 8'h1F};
    tbl[5] = '{1'b0, 4'd2,  4'd3,  1'b0, 8'h06};
    tbl[6] = '{1'b1, 4'd0,  4'd0,  1'b1, 8'h01};
    tbl[7] = '{1'b0, 4'd3,  4'd4,  1'b1, 8'h0C};
    tbl[8] = '{1'b0, 4'd15, 4'd1,  1'b0, 8'h0F};
    tbl[9] = '{1'b1, 4'd15, 4'd0,  1'b0, 8'h0F};

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", {22'd0, busy, done, r}, 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, 1'b1, $sformatf("tbl%0d", i));

    // start held high: ops every W+2 cycles, mid-run operand changes ignored
    a = 4'd3; b = 4'd5; op = 1'b0; start = 1'b1;
    cyc = 0; ndone = 0; last = -1; run = 0; maxrun = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        run++;
        chk("held_r", 32'(r), 32'h0F);
        if (last >= 0) chk("held_period", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        ndone++;
        a = 4'd3; b = 4'd5;
      end else begin
        run = 0;
        if (busy) begin a = 4'd15; b = 4'd15; end
      end
      if (run > maxrun) maxrun = run;
    end
    start = 1'b0;
    chk("held_count", 32'(ndone), 32'd3);
    chk("held_pulse_width", 32'(maxrun), 32'd1);
    @(posedge clk); #1;

    // reset during the second RUN cycle of 7x7
    op = 1'b0; a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen = 1'b1;
      chk("abort_state", {22'd0, busy, done, r}, 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(1'b0, 4'd2, 4'd3, 1'b0, 8'h06, 1'b0, "post_abort");

    for (int i = 0; i < 256; i++) begin
      x = W'(i >> 4); y = W'(i);
      run_op(1'b0, x, y, 1'b0, ref_r(1'b0, x, y, 1'b0), 1'b1, "exh_mul");
    end
    for (int i = 0; i < 512; i++) begin
      x = W'(i >> 5); y = W'(i >> 1); ci = 1'(i);
      run_op(1'b1, x, y, ci, ref_r(1'b1, x, y, ci), 1'b1, "exh_add");
    end

    for (int i = 0; i < 200; i++) begin
      o = 1'($urandom); x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_op(o, x, y, ci, ref_r(o, x, y, ci), 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
